// File: rtl/exec_stage.sv
// exec_stage: multi-cycle execute/writeback stage that owns the write port of the 4x8 register file.
// Define EXEC_MUL_EN to build the shift-add multiplier for opcode 111. Without it, 111 retires with no write.
module exec_stage #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [REG_AW-1:0] in_rs,
    input  logic [REG_AW-1:0] in_rt,
    input  logic [REG_AW-1:0] in_rd,
    output logic [REG_AW-1:0] rf_read_reg1,
    output logic [REG_AW-1:0] rf_read_reg2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    output logic              rf_write,
    output logic [REG_AW-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              flag_z,
    output logic              flag_c,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

`ifdef EXEC_MUL_EN
    typedef enum logic [2:0] {IDLE = 3'd0, RD1 = 3'd1, RD2 = 3'd2, MUL = 3'd3, WB = 3'd4} state_t;
`else
    typedef enum logic [2:0] {IDLE = 3'd0, RD1 = 3'd1, RD2 = 3'd2, WB = 3'd4} state_t;
`endif

    state_t              state_r;
    state_t              state_nx_s;
    logic [2:0]          op_r;
    logic [REG_AW-1:0]   rd_r;
    logic [DATA_W:0]     alu_s;

    // Single-cycle ALU; bit DATA_W carries carry, borrow or the last bit shifted out.
    function automatic logic [DATA_W:0] alu_f(input logic [2:0] op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        logic [DATA_W:0] r;
        logic [DATA_W:0] t;
        r = {(DATA_W+1){1'b0}};
        t = {a, 1'b0} >> b[2:0];
        case (op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            OP_SHL:  r = {1'b0, a} << b[2:0];
            OP_SHR:  r = {t[0], t[DATA_W:1]};
            default: r = {(DATA_W+1){1'b0}};
        endcase
        return r;
    endfunction

    // ALU result from the operands presented by the register file during RD2.
    always_comb begin
        alu_s = alu_f(op_r, rf_read_data1, rf_read_data2);
    end

`ifdef EXEC_MUL_EN
    localparam int CNT_W = $clog2(DATA_W);

    logic [2*DATA_W-1:0] acc_r;
    logic [2*DATA_W-1:0] mcand_r;
    logic [2*DATA_W-1:0] acc_nx_s;
    logic [DATA_W-1:0]   mplier_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                mul_last_s;

    assign acc_nx_s   = acc_r + (mplier_r[0] ? mcand_r : {(2*DATA_W){1'b0}});
    assign mul_last_s = (cnt_r == CNT_W'(DATA_W - 1));

    // Shift-add multiplier: operands loaded in RD2, one multiplier bit retired per MUL cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r    <= {(2*DATA_W){1'b0}};
            mcand_r  <= {(2*DATA_W){1'b0}};
            mplier_r <= {DATA_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else if (state_r == RD2) begin
            acc_r    <= {(2*DATA_W){1'b0}};
            mcand_r  <= {{DATA_W{1'b0}}, rf_read_data1};
            mplier_r <= rf_read_data2;
            cnt_r    <= {CNT_W{1'b0}};
        end else if (state_r == MUL) begin
            acc_r    <= acc_nx_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CNT_W'(1);
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; in_valid is only looked at in IDLE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nx_s = RD1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RD1: state_nx_s = RD2;
            RD2: begin
                if (op_r == OP_MUL) begin
`ifdef EXEC_MUL_EN
                    state_nx_s = MUL;
`else
                    state_nx_s = IDLE;
`endif
                end else begin
                    state_nx_s = WB;
                end
            end
`ifdef EXEC_MUL_EN
            MUL: begin
                if (mul_last_s) begin
                    state_nx_s = WB;
                end else begin
                    state_nx_s = MUL;
                end
            end
`endif
            WB:      state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Instruction latch, read addresses and the registered write port / flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r          <= 3'b000;
            rd_r          <= {REG_AW{1'b0}};
            rf_read_reg1  <= {REG_AW{1'b0}};
            rf_read_reg2  <= {REG_AW{1'b0}};
            rf_write      <= 1'b0;
            rf_write_reg  <= {REG_AW{1'b0}};
            rf_write_data <= {DATA_W{1'b0}};
            flag_z        <= 1'b0;
            flag_c        <= 1'b0;
            done          <= 1'b0;
        end else begin
            rf_write <= 1'b0;
            done     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        op_r         <= in_op;
                        rd_r         <= in_rd;
                        rf_read_reg1 <= in_rs;
                        rf_read_reg2 <= in_rt;
                    end
                end
                RD2: begin
                    if (op_r != OP_MUL) begin
                        rf_write      <= 1'b1;
                        done          <= 1'b1;
                        rf_write_reg  <= rd_r;
                        rf_write_data <= alu_s[DATA_W-1:0];
                        flag_z        <= (alu_s[DATA_W-1:0] == {DATA_W{1'b0}});
                        flag_c        <= alu_s[DATA_W];
                    end
                end
`ifdef EXEC_MUL_EN
                MUL: begin
                    if (mul_last_s) begin
                        rf_write      <= 1'b1;
                        done          <= 1'b1;
                        rf_write_reg  <= rd_r;
                        rf_write_data <= acc_nx_s[DATA_W-1:0];
                        flag_z        <= (acc_nx_s[DATA_W-1:0] == {DATA_W{1'b0}});
                        flag_c        <= (acc_nx_s[2*DATA_W-1:DATA_W] != {DATA_W{1'b0}});
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign in_ready = (state_r == IDLE) && !reset;
    assign busy     = (state_r != IDLE);

endmodule

// File: tb/tb_exec_stage.sv
// Bench for exec_stage: behavioural register file, directed vector table, hand sequences and
// randomized instructions scored against an arithmetic reference model.
module tb_exec_stage;

`ifdef EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [1:0] in_rs, in_rt, in_rd;
    logic [1:0] rf_read_reg1, rf_read_reg2, rf_write_reg;
    logic [7:0] rf_read_data1, rf_read_data2, rf_write_data;
    logic       rf_write, flag_z, flag_c, busy, done;

    exec_stage #(.DATA_W(8), .REG_AW(2)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .rf_write(rf_write), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
        .flag_z(flag_z), .flag_c(flag_c), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: registered reads, negedge writes, plus a bench-side preload path.
    logic [7:0] rf [4];
    logic [7:0] pre_val [4];
    logic [3:0] pre_mask;

    always @(posedge clk) begin
        rf_read_data1 <= rf[rf_read_reg1];
        rf_read_data2 <= rf[rf_read_reg2];
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (pre_mask[i]) rf[i] <= pre_val[i];
        end
        if (rf_write) rf[rf_write_reg] <= rf_write_data;
    end

    int pass_cnt = 0;
    int total_cnt = 0;
    int exp_regs [4];
    int exp_z = 0, exp_c = 0;
    bit noise_en = 1'b0;
    int o_wr_cyc, o_rdy_cyc, o_wr_cnt, o_done_cnt, o_wreg, o_wdata, o_z, o_c, o_done_wr, o_busy1;

    task automatic check(input string tag, input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s %s: actual=0x%0h required=0x%0h", tag, name, act, exp);
    endtask

    // Reference model straight from the opcode definitions, using integer arithmetic.
    task automatic model(input int op, input int a, input int b, output int res, output int c);
        int s;
        s = b % 8;
        c = 0;
        res = 0;
        case (op)
            0: begin res = a + b; c = int'(res > 255); end
            1: begin res = a - b; c = int'(a < b); end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: begin res = a << s; c = (s != 0) ? ((a >> (8 - s)) & 1) : 0; end
            6: begin res = a >> s; c = (s != 0) ? ((a >> (s - 1)) & 1) : 0; end
            7: begin res = a * b; c = int'(res > 255); end
            default: ;
        endcase
        res = res & 255;
    endtask

    // Called at posedge+1 in IDLE; returns at posedge+1 of the first cycle in_ready is back.
    task automatic load_one(input int idx, input int val);
        pre_val[idx] = 8'(val);
        pre_mask = 4'(1 << idx);
        @(negedge clk); #1;
        pre_mask = 4'b0000;
        exp_regs[idx] = val;
        @(posedge clk); #1;
    endtask

    task automatic exec_one(input int op, input int rs, input int rt, input int rd);
        in_valid = 1'b1;
        in_op = 3'(op); in_rs = 2'(rs); in_rt = 2'(rt); in_rd = 2'(rd);
        @(posedge clk); #1;
        in_valid = 1'b0;
        o_wr_cyc = 0; o_rdy_cyc = 0; o_wr_cnt = 0; o_done_cnt = 0; o_done_wr = 0;
        o_wreg = 0; o_wdata = 0; o_z = 0; o_c = 0;
        o_busy1 = int'(busy);
        for (int cyc = 1; cyc <= 24; cyc++) begin
            if (rf_write) begin
                o_wr_cnt++;
                if (o_wr_cyc == 0) begin
                    o_wr_cyc = cyc; o_wreg = int'(rf_write_reg); o_wdata = int'(rf_write_data);
                    o_z = int'(flag_z); o_c = int'(flag_c); o_done_wr = int'(done);
                end
            end
            if (done) o_done_cnt++;
            if (in_ready) begin
                o_rdy_cyc = cyc;
                break;
            end
            if (noise_en) begin
                in_valid = 1'($urandom_range(0, 1));
                in_op = 3'($urandom); in_rs = 2'($urandom); in_rt = 2'($urandom); in_rd = 2'($urandom);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // lat == 0 means the instruction must retire with no write and flags untouched.
    task automatic cmp_result(input string tag, input int lat, input int rd, input int data,
                              input int z, input int c);
        check(tag, "busy", o_busy1, 1);
        if (lat != 0) begin
            check(tag, "write_cycle", o_wr_cyc, lat);
            check(tag, "write_reg", o_wreg, rd);
            check(tag, "write_data", o_wdata, data);
            check(tag, "flag_z", o_z, z);
            check(tag, "flag_c", o_c, c);
            check(tag, "done_with_write", o_done_wr, 1);
            check(tag, "write_pulses", o_wr_cnt, 1);
            check(tag, "done_pulses", o_done_cnt, 1);
            check(tag, "ready_cycle", o_rdy_cyc, lat + 1);
            check(tag, "regfile", int'(rf[2'(rd)]), data);
            exp_regs[rd] = data; exp_z = z; exp_c = c;
        end else begin
            check(tag, "write_pulses", o_wr_cnt, 0);
            check(tag, "done_pulses", o_done_cnt, 0);
            check(tag, "ready_cycle", o_rdy_cyc, 3);
            check(tag, "flag_z_kept", int'(flag_z), z);
            check(tag, "flag_c_kept", int'(flag_c), c);
        end
    endtask

    task automatic model_instr(input string tag, input int op, input int rs, input int rt, input int rd);
        int res, c, lat;
        model(op, exp_regs[rs], exp_regs[rt], res, c);
        lat = (op == 7) ? (MUL_EN ? 11 : 0) : 3;
        exec_one(op, rs, rt, rd);
        if (lat != 0) cmp_result(tag, lat, rd, res, int'(res == 0), c);
        else cmp_result(tag, 0, 0, 0, exp_z, exp_c);
    endtask

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] rs, rt, rd;
        logic [7:0] a, b, res;
        logic       z, c;
        logic [4:0] lat;
    } vec_t;
    vec_t vq[$];

    task automatic add(input int op, input int rs, input int rt, input int rd, input int a,
                       input int b, input int res, input int z, input int c, input int lat);
        vec_t v;
        v.op = 3'(op); v.rs = 2'(rs); v.rt = 2'(rt); v.rd = 2'(rd);
        v.a = 8'(a); v.b = 8'(b); v.res = 8'(res); v.z = 1'(z); v.c = 1'(c); v.lat = 5'(lat);
        vq.push_back(v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seen, rst_edges;
        reset = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_rs = 2'd0; in_rt = 2'd0; in_rd = 2'd0;
        pre_mask = 4'b0000;
        for (int i = 0; i < 4; i++) pre_val[i] = 8'h00;

        // Directed vectors: {op, rs, rt, rd, A, B, result, z, c, latency}.
        add(0, 1, 2, 3, 8'h7F, 8'h01, 8'h80, 0, 0, 3);
        add(0, 1, 2, 3, 8'hFF, 8'h01, 8'h00, 1, 1, 3);
        add(1, 2, 1, 0, 8'h01, 8'hFF, 8'h02, 0, 1, 3);
        add(5, 0, 1, 2, 8'h81, 8'h01, 8'h02, 0, 1, 3);
        add(6, 0, 1, 2, 8'h81, 8'h01, 8'h40, 0, 1, 3);
        add(5, 0, 1, 2, 8'h81, 8'h08, 8'h81, 0, 0, 3);
        add(6, 3, 1, 0, 8'h81, 8'h07, 8'h01, 0, 0, 3);
        add(5, 3, 2, 1, 8'hE0, 8'h03, 8'h00, 1, 1, 3);
        add(2, 1, 2, 3, 8'hF0, 8'h3C, 8'h30, 0, 0, 3);
        add(3, 2, 3, 0, 8'hF0, 8'h0F, 8'hFF, 0, 0, 3);
        add(4, 0, 1, 2, 8'hAA, 8'hAA, 8'h00, 1, 0, 3);
        add(1, 1, 0, 3, 8'h05, 8'h05, 8'h00, 1, 0, 3);
        add(7, 1, 2, 0, 8'h10, 8'h10, 8'h00, 1, 1, MUL_EN ? 11 : 0);
        add(7, 2, 3, 1, 8'h0C, 8'h0A, 8'h78, 0, 0, MUL_EN ? 11 : 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset", "in_ready", int'(in_ready), 0);
        check("reset", "busy", int'(busy), 0);
        check("reset", "write_port", {rf_write, done, rf_write_reg, rf_write_data}, 0);
        check("reset", "read_regs_flags", {rf_read_reg1, rf_read_reg2, flag_z, flag_c}, 0);
        reset = 1'b0;
        #1;
        check("release", "in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) load_one(i, i * 17);

        foreach (vq[k]) begin
            load_one(int'(vq[k].rs), int'(vq[k].a));
            load_one(int'(vq[k].rt), int'(vq[k].b));
            exec_one(int'(vq[k].op), int'(vq[k].rs), int'(vq[k].rt), int'(vq[k].rd));
            if (vq[k].lat != 5'd0)
                cmp_result($sformatf("vec%0d", k), int'(vq[k].lat), int'(vq[k].rd), int'(vq[k].res),
                           int'(vq[k].z), int'(vq[k].c));
            else
                cmp_result($sformatf("vec%0d", k), 0, 0, 0, exp_z, exp_c);
        end

        // Back-to-back dependency: second ADD must read the first one's result.
        load_one(1, 5);
        load_one(2, 3);
        exec_one(0, 1, 2, 1);
        cmp_result("dep_first", 3, 1, 8'h08, 0, 0);
        exec_one(0, 1, 2, 3);
        cmp_result("dep_second", 3, 3, 8'h0B, 0, 0);

        // Reset in flight (MUL after 4 iterations, else during RD2): nothing written, outputs cleared.
        load_one(1, 8'hF0);
        load_one(2, 8'h20);
        exec_one(0, 1, 2, 3);
        cmp_result("pre_reset_add", 3, 3, 8'h10, 0, 1);
        rst_edges = MUL_EN ? 6 : 1;
        in_valid = 1'b1; in_op = MUL_EN ? 3'd7 : 3'd0; in_rs = 2'd1; in_rt = 2'd2; in_rd = 2'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (rst_edges) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midreset", "in_ready", int'(in_ready), 0);
        check("midreset", "busy", int'(busy), 0);
        check("midreset", "write_port", {rf_write, done, rf_write_reg, rf_write_data}, 0);
        check("midreset", "read_regs_flags", {rf_read_reg1, rf_read_reg2, flag_z, flag_c}, 0);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (rf_write || done) seen++;
        end
        check("midreset", "no_write_in_reset", seen, 0);
        reset = 1'b0;
        #1;
        check("midreset", "ready_after_release", int'(in_ready), 1);
        @(posedge clk); #1;
        check("midreset", "rd_untouched", int'(rf[0]), exp_regs[0]);
        exp_z = 0; exp_c = 0;
        model_instr("post_reset_add", 0, 2, 2, 1);

        // Randomized instructions with junk on the input while busy.
        noise_en = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) load_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
            model_instr($sformatf("rand%0d", n), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        noise_en = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
